// File: rtl/spi_feeder_pkg.sv
// Shared types and constants for the SPI transmit feeder.
// Provides the FSM state encoding, default parameter values and small
// width helpers used by the FIFO and the feeder itself.
package spi_feeder_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_GAP_CYC     = 4;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    // Pointer width for a power-of-2 FIFO depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: one extra bit so a full FIFO (level == depth) fits.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of a counter that must reach n-1; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy.
// Ports:
//   clk, reset      - clock and synchronous active-high reset (clears pointers)
//   push, push_data - write request; ignored while full
//   pop             - read request; ignored while empty
//   head            - entry at the read pointer (valid while !empty)
//   full, empty     - derived from the registered occupancy
//   level           - current number of stored entries
module sync_fifo
    import spi_feeder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         head,
    output logic                      full,
    output logic                      empty,
    output logic [lvl_w(DEPTH)-1:0]   level
);

    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
    assign level = count;

    // Storage is not reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_tx_feeder.sv
// Feeds queued bytes to spi_master one at a time.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   wr_valid     - producer offers wr_data
//   wr_data      - byte to queue
//   wr_ready     - FIFO has room
//   spi_start    - one-cycle start pulse to spi_master
//   spi_data     - byte for spi_master; changes only when a byte is popped
//   spi_done     - completion from spi_master (pulse or level)
//   busy         - a transfer is in flight or bytes are queued
//   level        - FIFO occupancy
//   timeout_err  - sticky watchdog flag, cleared only by reset
//   fsm_state    - current FSM state, for observation
//
// Handshake: a byte is accepted on every rising clk edge where
// wr_valid && wr_ready; wr_ready does not depend on wr_valid, and the
// producer must keep wr_data stable while wr_valid is high and wr_ready low.
module spi_tx_feeder
    import spi_feeder_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ready,
    output logic                      spi_start,
    output logic [DATA_W-1:0]         spi_data,
    input  logic                      spi_done,
    output logic                      busy,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      timeout_err,
    output state_t                    fsm_state
);

    localparam int GW = cnt_w(GAP_CYC);
    localparam int WW = cnt_w(TIMEOUT_CYC);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYC - 1);
    // With no gap configured the GAP state is skipped entirely.
    localparam state_t AFTER_WAIT = (GAP_CYC > 0) ? GAP : IDLE;

    state_t            state;
    state_t            state_nxt;
    logic              done_q;
    logic              done_rise;
    logic              wd_expire;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic [GW-1:0]     gap_cnt;
    logic [WW-1:0]     wd_cnt;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // Only rising edges count, so a level-style done is consumed once.
    assign done_rise = spi_done && !done_q;
    assign wd_expire = (wd_cnt == WD_LAST);
    assign pop       = (state == IDLE) && !empty;
    assign wr_ready  = !full;
    assign busy      = (state != IDLE) || !empty;
    assign fsm_state = state;

    always_comb begin
        state_nxt = state;
        spi_start = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) state_nxt = START;
            end
            START: begin
                spi_start = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done_rise wins over a same-cycle expiry.
                if (done_rise || wd_expire) state_nxt = AFTER_WAIT;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            spi_data    <= '0;
            timeout_err <= 1'b0;
            gap_cnt     <= '0;
            wd_cnt      <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= spi_done;
            if (pop) begin
                spi_data <= head;
            end
            if (state == WAIT_DONE && !done_rise && wd_expire) begin
                timeout_err <= 1'b1;
            end
            // Both counters run only inside their state and restart at zero.
            gap_cnt <= (state == GAP)       ? gap_cnt + GW'(1) : '0;
            wd_cnt  <= (state == WAIT_DONE) ? wd_cnt + WW'(1)  : '0;
        end
    end

endmodule

// File: tb/tb_spi_tx_feeder.sv
module tb_spi_tx_feeder;
    import spi_feeder_pkg::*;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 8;
    localparam int GAP_CYC     = 4;
    localparam int TIMEOUT_CYC = 1024;
    localparam int LIMIT       = 2000;

    logic              clk;
    logic              reset;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              spi_start;
    logic [DATA_W-1:0] spi_data;
    logic              spi_done;
    logic              busy;
    logic [3:0]        level;
    logic              timeout_err;
    state_t            fsm_state;

    int checks    = 0;
    int errors    = 0;
    int start_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    spi_tx_feeder #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .spi_start   (spi_start),
        .spi_data    (spi_data),
        .spi_done    (spi_done),
        .busy        (busy),
        .level       (level),
        .timeout_err (timeout_err),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Offer one byte and hold it until accepted.
    task automatic push(input logic [DATA_W-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        for (int i = 0; i < LIMIT; i++) begin
            if (wr_ready) begin
                exp_q.push_back(d);
                cyc();
                wr_valid = 1'b0;
                return;
            end
            cyc();
        end
        wr_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL push_timeout: got wr_ready 0 expected 1 within %0d cycles", LIMIT);
    endtask

    // Cycles from now until spi_start is seen (0 if it is high now).
    task automatic wait_start(output int n);
        for (int i = 0; i < LIMIT; i++) begin
            if (spi_start) begin
                n = i;
                return;
            end
            cyc();
        end
        n = -1;
        checks++;
        errors++;
        $display("FAIL wait_start: got no spi_start expected one within %0d cycles", LIMIT);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < LIMIT; i++) begin
            if (!busy) return;
            cyc();
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: got busy 1 expected 0 within %0d cycles", LIMIT);
    endtask

    // Step into WAIT_DONE, then a one-cycle done; returns one cycle after it.
    task automatic done_pulse();
        cyc();
        spi_done = 1'b1;
        cyc();
        spi_done = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && spi_start) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: got data %0h expected no start", spi_data);
            end else begin
                check("spi_data", 32'(spi_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        int s0;

        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        spi_done = 1'b0;
        repeat (2) cyc();
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_spi_start", 32'(spi_start), 0);
        check("rst_spi_data", 32'(spi_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_level", 32'(level), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        reset = 1'b0;
        cyc();

        // Single byte: push cycle, pop cycle, then spi_start on the second cycle.
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        cyc();
        wr_valid = 1'b0;
        wait_start(n);
        check("start_latency", n, 1);
        repeat (3) cyc();
        check("data_hold", 32'(spi_data), 32'h A5);
        check("busy_wait", 32'(busy), 1);
        spi_done = 1'b1;
        cyc();
        spi_done = 1'b0;
        repeat (GAP_CYC - 1) cyc();
        check("busy_in_gap", 32'(busy), 1);
        cyc();
        check("busy_after_gap", 32'(busy), 0);

        // Burst to full while the master sits on the first byte.
        push(8'hEE);
        wait_start(n);
        for (int i = 0; i < 8; i++) push(8'(i));
        check("full_level", 32'(level), 8);
        check("full_wr_ready", 32'(wr_ready), 0);
        wr_valid = 1'b1;
        wr_data  = 8'h08;
        exp_q.push_back(8'h08);
        repeat (3) cyc();
        check("held_9th_level", 32'(level), 8);
        done_pulse();
        wait_start(n);
        check("gap_cycles", n, GAP_CYC + 1);
        check("ready_after_pop", 32'(wr_ready), 1);
        cyc();
        wr_valid = 1'b0;
        check("refill_level", 32'(level), 8);
        for (int i = 0; i < 8; i++) begin
            done_pulse();
            wait_start(n);
            check("burst_gap", n, GAP_CYC + 1);
        end
        done_pulse();
        wait_idle();

        // Level-style done: one byte per rising edge only.
        push(8'h11);
        push(8'h22);
        wait_start(n);
        cyc();
        s0 = start_cnt;
        spi_done = 1'b1;
        repeat (20) cyc();
        check("level_done_starts", start_cnt - s0, 1);
        spi_done = 1'b0;
        repeat (6) cyc();
        check("no_restart", start_cnt - s0, 1);
        check("busy_stuck", 32'(busy), 1);
        done_pulse();
        wait_idle();
        check("level_empty", 32'(level), 0);

        // Push in the same cycle the FSM pops: level unchanged, order kept.
        push(8'h77);
        wait_start(n);
        push(8'h3C);
        push(8'h5A);
        push(8'h96);
        check("level_three", 32'(level), 3);
        done_pulse();
        repeat (GAP_CYC) cyc();
        check("level_pre_pop", 32'(level), 3);
        wr_valid = 1'b1;
        wr_data  = 8'hC3;
        exp_q.push_back(8'hC3);
        cyc();
        wr_valid = 1'b0;
        check("level_push_pop", 32'(level), 3);
        check("start_after_pop", 32'(spi_start), 1);
        for (int i = 0; i < 3; i++) begin
            done_pulse();
            wait_start(n);
            check("pp_gap", n, GAP_CYC + 1);
        end
        done_pulse();
        wait_idle();

        // Watchdog: flag rises TIMEOUT_CYC edges after the edge that sampled spi_start.
        push(8'h3C);
        push(8'h5A);
        wait_start(n);
        repeat (TIMEOUT_CYC) cyc();
        check("err_before", 32'(timeout_err), 0);
        cyc();
        check("err_at_timeout", 32'(timeout_err), 1);
        check("state_gap", 32'(fsm_state), 32'(GAP));
        wait_start(n);
        check("restart_after_timeout", n, GAP_CYC + 1);
        done_pulse();
        wait_idle();
        check("err_sticky", 32'(timeout_err), 1);

        // Reset during WAIT_DONE with four bytes queued.
        push(8'h81);
        wait_start(n);
        push(8'h82);
        push(8'h83);
        push(8'h84);
        push(8'h85);
        check("pre_reset_level", 32'(level), 4);
        check("pre_reset_state", 32'(fsm_state), 32'(WAIT_DONE));
        reset = 1'b1;
        cyc();
        check("mid_rst_wr_ready", 32'(wr_ready), 1);
        check("mid_rst_spi_start", 32'(spi_start), 0);
        check("mid_rst_spi_data", 32'(spi_data), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_timeout_err", 32'(timeout_err), 0);
        exp_q.delete();
        reset = 1'b0;
        s0 = start_cnt;
        cyc();
        spi_done = 1'b1;
        cyc();
        spi_done = 1'b0;
        repeat (10) cyc();
        check("late_done_no_start", start_cnt - s0, 0);
        check("late_done_busy", 32'(busy), 0);
        check("late_done_state", 32'(fsm_state), 32'(IDLE));

        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
